box_filter_fifo: RTL and testbench



---
 rtl/box_filter_fifo_pkg.sv | 15 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/box_filter_fifo.sv | 111 +++++++++++
 tb/tb_box_filter_fifo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/box_filter_fifo_pkg.sv
// Shared defaults and entry layout for the box filter FIFO.
package box_filter_fifo_pkg;

  localparam int unsigned N_DEFAULT     = 16;
  localparam int unsigned CW_DEFAULT    = 8;
  localparam int unsigned DEPTH_DEFAULT = 8;

  localparam logic [7:0] KEPT_MAX = 8'd255;

  // Entry layout, MSB to LSB: marker, last, conf[CW], y2, x2, y1, x1 (N bits each).
  function automatic int unsigned entry_width(int unsigned n, int unsigned cw);
    return 4 * n + cw + 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with valid/ready on both sides.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = 1;
  localparam logic [AW:0]   CNT_ONE    = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push, pop;

  assign in_ready  = count_q < FULL_COUNT;
  assign out_valid = count_q != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/box_filter_fifo.sv
// Confidence filter and centre-to-corner conversion in front of a box FIFO, with per-frame counts.
module box_filter_fifo
  import box_filter_fifo_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned CW    = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_bx,
  input  logic [N-1:0]  in_by,
  input  logic [N-1:0]  in_bw,
  input  logic [N-1:0]  in_bh,
  input  logic [CW-1:0] in_conf,
  input  logic          in_last,
  input  logic [CW-1:0] conf_thresh,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_x1,
  output logic [N-1:0]  out_y1,
  output logic [N-1:0]  out_x2,
  output logic [N-1:0]  out_y2,
  output logic [CW-1:0] out_conf,
  output logic          out_last,
  output logic          out_marker,
  output logic [7:0]    kept_count,
  output logic          frame_done
);

  localparam int unsigned EW = entry_width(N, CW);

  function automatic logic [N-1:0] lo_corner(logic [N-1:0] c, logic [N-1:0] s);
    logic [N-1:0] half;
    half = s >> 1;
    return (c >= half) ? c - half : '0;
  endfunction

  function automatic logic [N-1:0] hi_corner(logic [N-1:0] c, logic [N-1:0] s);
    logic [N:0] sum;
    sum = {1'b0, c} + {1'b0, s >> 1};
    return sum[N] ? '1 : sum[N-1:0];
  endfunction

  logic          init_q, fd_q;
  logic [7:0]    run_q, kept_q, run_inc;
  logic          fifo_in_ready, fifo_out_valid;
  logic          accept, keep, wr;
  logic [EW-1:0] wr_data, rd_data;

  // in_ready is held low through reset and for the edge it is released on.
  assign in_ready = init_q && fifo_in_ready;
  assign accept   = in_valid && in_ready;
  assign keep     = in_conf >= conf_thresh;
  assign wr       = accept && (keep || in_last);
  assign run_inc  = (run_q == KEPT_MAX) ? run_q : run_q + 8'd1;

  always_comb begin
    wr_data = {2'b11, {(EW - 2){1'b0}}};
    if (keep) begin
      wr_data = {1'b0, in_last, in_conf,
                 hi_corner(in_by, in_bh), hi_corner(in_bx, in_bw),
                 lo_corner(in_by, in_bh), lo_corner(in_bx, in_bw)};
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (wr),
    .in_ready  (fifo_in_ready),
    .in_data   (wr_data),
    .out_valid (fifo_out_valid),
    .out_ready (out_ready),
    .out_data  (rd_data)
  );

  // Storage is not reset, so data is masked while the FIFO is empty.
  assign out_valid = fifo_out_valid;
  assign {out_marker, out_last, out_conf, out_y2, out_x2, out_y1, out_x1} =
      fifo_out_valid ? rd_data : '0;

  assign kept_count = kept_q;
  assign frame_done = fd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q <= 1'b0;
      run_q  <= '0;
      kept_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      init_q <= 1'b1;
      fd_q   <= accept && in_last;
      if (accept) begin
        if (in_last) begin
          kept_q <= keep ? run_inc : run_q;
          run_q  <= '0;
        end else if (keep) begin
          run_q <= run_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_box_filter_fifo.sv
// Scoreboard bench for box_filter_fifo: filter, corner maths, backpressure, frame counts, reset.
module tb_box_filter_fifo;

  localparam int N = 16, CW = 8, DEPTH = 8;

  logic          clk, rst;
  logic          in_valid, in_ready, in_last;
  logic [N-1:0]  in_bx, in_by, in_bw, in_bh;
  logic [CW-1:0] in_conf, conf_thresh;
  logic          out_valid, out_ready, out_last, out_marker, frame_done;
  logic [N-1:0]  out_x1, out_y1, out_x2, out_y2;
  logic [CW-1:0] out_conf;
  logic [7:0]    kept_count;
  logic [73:0]   obs;

  box_filter_fifo #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_bx (in_bx), .in_by (in_by), .in_bw (in_bw), .in_bh (in_bh),
    .in_conf (in_conf), .in_last (in_last), .conf_thresh (conf_thresh),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_x1 (out_x1), .out_y1 (out_y1), .out_x2 (out_x2), .out_y2 (out_y2),
    .out_conf (out_conf), .out_last (out_last), .out_marker (out_marker),
    .kept_count (kept_count), .frame_done (frame_done)
  );

  assign obs = {out_marker, out_last, out_conf, out_y2, out_x2, out_y1, out_x1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int run_model = 0, kept_model = 0, frames = 0, fd_seen = 0;
  logic [73:0] sb[$];
  logic [73:0] held;
  bit hold_pend = 0;

  task automatic check_eq(string tag, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] lo_ref(int c, int s);
    int v = c - s / 2;
    return (v < 0) ? 16'd0 : 16'(v);
  endfunction

  function automatic logic [15:0] hi_ref(int c, int s);
    int v = c + s / 2;
    return (v > 65535) ? 16'hffff : 16'(v);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(int bx, int by, int bw, int bh, int conf, bit last);
    int t = 0;
    in_valid = 1'b1;
    in_bx = 16'(bx); in_by = 16'(by); in_bw = 16'(bw); in_bh = 16'(bh);
    in_conf = 8'(conf); in_last = last;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check_eq("in_ready_timeout", in_ready, 1);
    end else begin
      if (conf >= int'(conf_thresh)) begin
        sb.push_back({1'b0, last, 8'(conf), hi_ref(by, bh), hi_ref(bx, bw),
                      lo_ref(by, bh), lo_ref(bx, bw)});
        run_model = (run_model < 255) ? run_model + 1 : 255;
      end else if (last) begin
        sb.push_back({2'b11, 72'd0});
      end
      if (last) begin
        kept_model = run_model;
        run_model  = 0;
        frames++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(string tag);
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_eq(tag, 128'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_pend <= 1'b0;
    end else begin
      if (frame_done) fd_seen <= fd_seen + 1;
      if (out_valid) begin
        if (hold_pend) check_eq("hold", obs, held);
        if (out_ready) begin
          if (sb.size() == 0) check_eq("sb_empty", 128'(sb.size()), 1);
          else check_eq("out_entry", obs, sb.pop_front());
        end
      end
      hold_pend <= out_valid && !out_ready;
      held      <= obs;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; conf_thresh = 8'd100;
    in_bx = '0; in_by = '0; in_bw = '0; in_bh = '0; in_conf = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", obs, 0);
    check_eq("rst_kept", kept_count, 0);
    check_eq("rst_fd", frame_done, 0);
    rst = 1'b0;
    #1;
    check_eq("in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    check_eq("in_ready_after_edge", in_ready, 1);

    // Basic box and one-cycle latency into an empty FIFO.
    send(50, 40, 20, 10, 120, 0);
    check_eq("latency", out_valid, 1);
    wait_drain("drain_basic");

    // Saturating corners; second beat closes the frame.
    send(5, 0, 20, 0, 120, 0);
    send(65530, 100, 20, 10, 120, 1);
    check_eq("kept_sat_frame", kept_count, 8'(kept_model));
    wait_drain("drain_sat");

    // Filtered frame ending with a marker.
    send(1000, 1000, 10, 10, 50, 0);
    send(2000, 2000, 40, 60, 150, 0);
    send(3000, 3000, 8, 8, 200, 0);
    send(4000, 4000, 8, 8, 30, 1);
    check_eq("kept_frame", kept_count, 8'(kept_model));
    check_eq("kept_frame_two", kept_count, 2);
    repeat (3) @(posedge clk);
    #1;
    check_eq("fd_count", fd_seen, frames);
    wait_drain("drain_frame");

    // Backpressure: 10 beats against a stalled consumer.
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 10; i++) send(100 + i * 10, 200, 30, 40, 101 + i, i == 9);
      begin
        repeat (15) @(posedge clk);
        #1;
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_accepted", 128'(sb.size()), 8);
        out_ready = 1'b1;
      end
    join
    check_eq("kept_full", kept_count, 8'(kept_model));
    wait_drain("drain_full");

    // Concurrent read/write at occupancy 3.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535),
           $urandom_range(0, 65535), $urandom_range(100, 255), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_eq("cc_ready", in_ready, 1);
      send($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535),
           $urandom_range(0, 65535), $urandom_range(100, 255), 0);
    end
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("cc_occupancy", 128'(sb.size()), 3);
    check_eq("cc_out_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_drain("drain_cc");
    send(10, 10, 2, 2, 5, 1);
    check_eq("kept_cc", kept_count, 8'(kept_model));
    wait_drain("drain_cc_end");

    // Reset mid-frame with 5 entries stored.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(300 + i, 300, 4, 4, 150, 0);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_kept", kept_count, 0);
    check_eq("mid_rst_in_ready", in_ready, 0);
    check_eq("mid_rst_data", obs, 0);
    sb.delete();
    run_model = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send(500, 500, 20, 20, 110, 0);
    send(600, 600, 20, 20, 90, 0);
    send(700, 700, 20, 20, 130, 0);
    send(800, 800, 20, 20, 100, 1);
    check_eq("kept_after_rst", kept_count, 3);
    repeat (3) @(posedge clk);
    #1;
    check_eq("fd_after_rst", fd_seen, frames);
    wait_drain("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
